// File: rtl/sprite_bouncer_if.sv
// Sprite bouncer pixel/control bundle.
// Purpose : carries the vga_adapter pixel signals plus the bouncer's control
//           and status lines between the animator and its environment.
// Signals : enable, colour_in        - environment -> bouncer
//           x, y, colour, plot       - bouncer -> vga_adapter
//           busy, bounce_x, bounce_y - bouncer status
// Modports: master = bouncer side, slave = environment/adapter side.
interface sprite_bouncer_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7,
    parameter int unsigned CW = 3
);
    logic          enable;
    logic [CW-1:0] colour_in;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    logic          bounce_x;
    logic          bounce_y;

    modport master (
        input  enable, colour_in,
        output x, y, colour, plot, busy, bounce_x, bounce_y
    );

    modport slave (
        output enable, colour_in,
        input  x, y, colour, plot, busy, bounce_x, bounce_y
    );
endinterface

// File: rtl/sprite_bouncer.sv
// Bouncing-sprite animator for the vga_adapter pixel port.
// Purpose : once per frame tick, erase the solid sprite, move it by STEP with
//           edge reflection/clamping, then redraw it.
// Ports   : clk    - system clock
//           resetn - asynchronous active-low reset
//           bus    - sprite_bouncer_if.master (enable, colour_in in;
//                    x, y, colour, plot, busy, bounce_x, bounce_y out)
// Macro   : BOUNCER_ERASE_EN - when defined, the old sprite is erased before
//           each move; otherwise the sprite leaves a trail.
module sprite_bouncer #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned XW        = 8,
    parameter int unsigned YW        = 7,
    parameter int unsigned CW        = 3,
    parameter int unsigned BOX_W     = 4,
    parameter int unsigned BOX_H     = 4,
    parameter int unsigned STEP      = 1,
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic             clk,
    input  logic             resetn,
    sprite_bouncer_if.master bus
);
    localparam int unsigned     FCW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [XW:0]     STEP_X  = (XW+1)'(STEP);
    localparam logic [YW:0]     STEP_Y  = (YW+1)'(STEP);
    localparam logic [XW:0]     MAX_X   = (XW+1)'(SCREEN_W - BOX_W);
    localparam logic [YW:0]     MAX_Y   = (YW+1)'(SCREEN_H - BOX_H);
    localparam logic [XW-1:0]   CX_LAST = XW'(BOX_W - 1);
    localparam logic [YW-1:0]   CY_LAST = YW'(BOX_H - 1);
    localparam logic [FCW-1:0]  FC_LAST = FCW'(FRAME_DIV - 1);

`ifdef BOUNCER_ERASE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, MOVE = 2'd2, DRAW = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd2, DRAW = 2'd3} state_t;
`endif

    state_t          r_state;
    logic [XW-1:0]   r_pos_x;
    logic [YW-1:0]   r_pos_y;
    logic            r_dir_x;
    logic            r_dir_y;
    logic [XW-1:0]   r_cx;
    logic [YW-1:0]   r_cy;
    logic [FCW-1:0]  r_fcnt;

    logic            w_tick;
    logic [XW:0]     w_px_ext, w_fwd_x, w_nxt_x;
    logic [YW:0]     w_py_ext, w_fwd_y, w_nxt_y;
    logic            w_hit_x, w_hit_y;
    logic            w_row_end, w_last_px;
    logic            w_erase, w_plot;

    // Free-running frame divider; ticks landing outside IDLE are simply lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               r_fcnt <= '0;
        else if (r_fcnt == FC_LAST) r_fcnt <= '0;
        else                       r_fcnt <= r_fcnt + FCW'(1);
    end

    assign w_tick = (r_fcnt == FC_LAST);

    // Reflection/clamp per axis, one bit wider so pos+STEP cannot wrap.
    assign w_px_ext = {1'b0, r_pos_x};
    assign w_fwd_x  = w_px_ext + STEP_X;
    assign w_hit_x  = r_dir_x ? (w_fwd_x >= MAX_X) : (w_px_ext <= STEP_X);
    assign w_nxt_x  = r_dir_x ? (w_hit_x ? MAX_X : w_fwd_x)
                              : (w_hit_x ? '0 : (w_px_ext - STEP_X));

    assign w_py_ext = {1'b0, r_pos_y};
    assign w_fwd_y  = w_py_ext + STEP_Y;
    assign w_hit_y  = r_dir_y ? (w_fwd_y >= MAX_Y) : (w_py_ext <= STEP_Y);
    assign w_nxt_y  = r_dir_y ? (w_hit_y ? MAX_Y : w_fwd_y)
                              : (w_hit_y ? '0 : (w_py_ext - STEP_Y));

    assign w_row_end = (r_cx == CX_LAST);
    assign w_last_px = w_row_end && (r_cy == CY_LAST);

    // Sequencer: scan counters are always left at zero outside ERASE/DRAW.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_dir_x <= 1'b1;
            r_dir_y <= 1'b1;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick && bus.enable) begin
`ifdef BOUNCER_ERASE_EN
                        r_state <= ERASE;
`else
                        r_state <= MOVE;
`endif
                    end
                end
`ifdef BOUNCER_ERASE_EN
                ERASE: begin
                    if (w_row_end) begin
                        r_cx <= '0;
                        r_cy <= w_last_px ? '0 : (r_cy + YW'(1));
                    end else begin
                        r_cx <= r_cx + XW'(1);
                    end
                    if (w_last_px) r_state <= MOVE;
                end
`endif
                MOVE: begin
                    r_pos_x <= XW'(w_nxt_x);
                    r_pos_y <= YW'(w_nxt_y);
                    // A hit always reverses direction: forward->0, backward->1.
                    if (w_hit_x) r_dir_x <= ~r_dir_x;
                    if (w_hit_y) r_dir_y <= ~r_dir_y;
                    r_state <= DRAW;
                end
                DRAW: begin
                    if (w_row_end) begin
                        r_cx <= '0;
                        r_cy <= w_last_px ? '0 : (r_cy + YW'(1));
                    end else begin
                        r_cx <= r_cx + XW'(1);
                    end
                    if (w_last_px) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BOUNCER_ERASE_EN
    assign w_erase = (r_state == ERASE);
`else
    assign w_erase = 1'b0;
`endif
    assign w_plot = w_erase || (r_state == DRAW);

    // Moore outputs decoded straight from the registers.
    assign bus.x        = w_plot ? (r_pos_x + r_cx) : r_pos_x;
    assign bus.y        = w_plot ? (r_pos_y + r_cy) : r_pos_y;
    assign bus.colour   = (r_state == DRAW) ? bus.colour_in : '0;
    assign bus.plot     = w_plot;
    assign bus.busy     = (r_state != IDLE);
    assign bus.bounce_x = (r_state == MOVE) && w_hit_x;
    assign bus.bounce_y = (r_state == MOVE) && w_hit_y;
endmodule

// File: doc/sprite_bouncer.md
# sprite_bouncer

Parametrised bouncing-sprite animator for the 160x120 VGA pipeline: once per frame tick it erases a solid rectangular sprite, advances it by a configurable step with edge reflection, and redraws it. Drives the x/y/colour/plot inputs of the single vga_adapter instance. It generalises the fixed 4x4, step-1, free-running bouncer with:

- sized sprite and screen;
- variable step with clamping;
- an internal frame divider;
- enable and busy;
- per-axis bounce pulses.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- BOX_W, 4, sprite width (1..SCREEN_W)
- BOX_H, 4, sprite height (1..SCREEN_H)
- STEP, 1, pixels moved per frame per axis (1..min(SCREEN_W-BOX_W, SCREEN_H-BOX_H))
- FRAME_DIV, 833333, clocks per frame tick; must exceed 2*BOX_W*BOX_H+2

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- enable  in  1  when high, frame ticks start an update
- colour_in  in  CW  sprite colour, sampled every DRAW cycle
- x  out  XW  pixel x to adapter
- y  out  YW  pixel y to adapter
- colour  out  CW  pixel colour to adapter
- plot  out  1  pixel write strobe
- busy  out  1  high while an update is in progress
- bounce_x  out  1  one-cycle pulse on horizontal reflection
- bounce_y  out  1  one-cycle pulse on vertical reflection

## Operation
- Registers:
  - pos_x, pos_y: sprite top-left.
  - dir_x: 1 = right. dir_y: 1 = down.
  - cx, cy: in-sprite counters.
  - fcnt: frame divider, 0..FRAME_DIV-1.
  - state.
- Reset values: pos (0,0), dir_x=1, dir_y=1, cx=cy=0, fcnt=0, state IDLE. Hence x=0, y=0, colour=0, plot=0, busy=0, bounce_x=bounce_y=0.
- fcnt counts freely every cycle and wraps. tick = (fcnt==FRAME_DIV-1).
- States:
  - IDLE: if tick && enable, go to ERASE. Otherwise stay. A tick outside IDLE is dropped, not queued.
  - ERASE: plot black at (pos_x+cx, pos_y+cy). Row-major: cx increments, wraps at BOX_W-1 and increments cy. At cx=BOX_W-1 and cy=BOX_H-1, clear counters and go to MOVE.
  - MOVE: one cycle; update pos and dir; go to DRAW.
  - DRAW: same scan as ERASE with colour=colour_in, at the new position. Last pixel goes to IDLE.
- Outputs are Moore-decoded from registers:
  - ERASE/DRAW: plot=1, x=pos_x+cx, y=pos_y+cy.
  - IDLE/MOVE: plot=0, x=pos_x, y=pos_y, colour=0.
  - busy = (state!=IDLE).
  - bounce_x/bounce_y are asserted only in the MOVE cycle.
- Movement per axis (MAXX=SCREEN_W-BOX_W, MAXY=SCREEN_H-BOX_H):
  - Forward: if pos+STEP >= MAX, then pos=MAX, dir=0, bounce pulse. Otherwise pos += STEP.
  - Backward: if pos <= STEP, then pos=0, dir=1, bounce pulse. Otherwise pos -= STEP.
  - Compute in XW+1/YW+1 bits; no wrap-around is permitted.
- Both axes reflecting in the same MOVE: both pulses are high in the same cycle (corner).
- enable falling mid-update: the current update completes; there are no further updates.
- resetn low at any time: immediately forces the reset values, including mid-ERASE/DRAW. A partially drawn sprite is left on screen.

## Timing
- Let N=BOX_W*BOX_H. If tick && enable are in IDLE at cycle t:
  - ERASE occupies cycles t+1..t+N;
  - MOVE occupies t+N+1;
  - DRAW occupies t+N+2..t+2N+1;
  - IDLE resumes at t+2N+2.
- busy is high for 2N+1 cycles.
- plot is high for N cycles, low 1 cycle, then high N cycles.
- The first tick after reset release occurs FRAME_DIV-1 cycles after release.

## Configuration
- BOUNCER_ERASE_EN defined: full IDLE→ERASE→MOVE→DRAW sequence as above.
- BOUNCER_ERASE_EN undefined: the ERASE state is not compiled. The tick goes IDLE→MOVE→DRAW, leaving a trail.
  - MOVE at t+1, DRAW t+2..t+N+1.
  - busy is high N+1 cycles.
  - Reflection rules are unchanged.

## Test plan
- Reset: hold resetn low, then release with FRAME_DIV=64, BOX 4x4. Required: x=y=colour=plot=busy=0 through cycle 62; first plot at cycle 64.
- Frame sequence (erase enabled, colour_in=3'b101):
  - 16 plots colour 0 at (0..3,0..3), row-major.
  - 1 cycle plot=0.
  - 16 plots colour 5 at (1..4,1..4).
  - Then busy falls.
- Right-wall bounce (SCREEN_W=16, SCREEN_H=40, BOX 4x4, STEP=1):
  - Frame 12 moves pos_x 11→12 with a bounce_x pulse in MOVE and bounce_y=0.
  - Frame 13 draws at x=11..14.
- Corner and clamp (SCREEN 16x16, STEP=5): pos 0→5→10→12 with bounce_x and bounce_y high in the same cycle; next frame pos=7.
- Enable/reset mid-update:
  - enable dropped during DRAW: the draw completes, and no plot occurs on the next 3 ticks.
  - resetn pulsed during ERASE: plot=0 and pos=(0,0) immediately.
- Macro off: tick → plot first at t+2 at pos+STEP, 16 plots, busy high 17 cycles, no colour-0 pixels.
